// File: rtl/alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue controller that sits in front of an external combinational ALU.
// It accepts one request at a time and decodes the opcode or function field
// into an ALU operation. It presents the operands to the ALU for one EXEC
// cycle and captures the ALU outputs. The captured response is held until
// the consumer takes it.
//
// Request/response flow: IDLE (accept) -> EXEC (one cycle) -> DONE (hold
// until OutValid && OutReady) -> IDLE. An accept seen at the end of request
// cycle 0 gives OutValid in cycle 2, so the best case is one request every
// three cycles.
//
// Configuration macro:
//   ALU_CTRL_ILLEGAL_TRAP_EN - when defined, an undecodable request sends the
//                              block to TRAP, and it stays there until Reset.
//                              When undefined, an illegal request completes
//                              normally with OutIllegal=1, and Trap is tied
//                              to 0.
//
// Ports:
//   Clk, Reset               clock, synchronous active-high reset
//   InValid / InReady        request handshake
//   Opcode, Funct            instruction fields to decode
//   RegA, RegB               operands (RegB may be an extended immediate)
//   AluOp, AluA, AluB        registered drive to the ALU
//   AluResult, AluZero,
//   AluCarryOut              ALU outputs, sampled at the end of EXEC
//   OutValid / OutReady      response handshake
//   OutResult, OutZero,
//   OutCarry, OutBranchTaken,
//   OutIllegal               captured response fields
//   Trap                     high while parked in TRAP
// ----------------------------------------------------------------------------
module alu_issue_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic [31:0] RegA,
  input  logic [31:0] RegB,
  output logic [2:0]  AluOp,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  input  logic [31:0] AluResult,
  input  logic        AluZero,
  input  logic        AluCarryOut,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutResult,
  output logic        OutZero,
  output logic        OutCarry,
  output logic        OutBranchTaken,
  output logic        OutIllegal,
  output logic        Trap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2,
    S_TRAP = 2'd3
  } state_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_ILL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t      r_state;
  state_t      w_next_state;

  logic [2:0]  w_dec_op;
  logic        w_dec_illegal;
  logic        w_dec_beq;
  logic        w_dec_bne;
  logic        w_accept;

  logic [2:0]  r_alu_op;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic        r_illegal;
  logic        r_is_beq;
  logic        r_is_bne;
  logic [31:0] r_out_result;
  logic        r_out_zero;
  logic        r_out_carry;
  logic        r_out_branch;
  logic        r_out_illegal;

  // Instruction decode: every unlisted opcode/funct falls through as illegal
  always_comb begin
    w_dec_op      = ALU_ILL;
    w_dec_illegal = 1'b1;
    w_dec_beq     = 1'b0;
    w_dec_bne     = 1'b0;
    case (Opcode)
      OPC_RTYPE: begin
        case (Funct)
          FN_AND:  begin w_dec_op = ALU_AND; w_dec_illegal = 1'b0; end
          FN_OR:   begin w_dec_op = ALU_OR;  w_dec_illegal = 1'b0; end
          FN_ADD:  begin w_dec_op = ALU_ADD; w_dec_illegal = 1'b0; end
          FN_SUB:  begin w_dec_op = ALU_SUB; w_dec_illegal = 1'b0; end
          FN_SLT:  begin w_dec_op = ALU_SLT; w_dec_illegal = 1'b0; end
          default: begin w_dec_op = ALU_ILL; w_dec_illegal = 1'b1; end
        endcase
      end
      OPC_BEQ:  begin w_dec_op = ALU_SUB; w_dec_illegal = 1'b0; w_dec_beq = 1'b1; end
      OPC_BNE:  begin w_dec_op = ALU_SUB; w_dec_illegal = 1'b0; w_dec_bne = 1'b1; end
      OPC_ADDI: begin w_dec_op = ALU_ADD; w_dec_illegal = 1'b0; end
      OPC_LW:   begin w_dec_op = ALU_ADD; w_dec_illegal = 1'b0; end
      OPC_SW:   begin w_dec_op = ALU_ADD; w_dec_illegal = 1'b0; end
      OPC_ANDI: begin w_dec_op = ALU_AND; w_dec_illegal = 1'b0; end
      OPC_ORI:  begin w_dec_op = ALU_OR;  w_dec_illegal = 1'b0; end
      OPC_SLTI: begin w_dec_op = ALU_SLT; w_dec_illegal = 1'b0; end
      default:  begin w_dec_op = ALU_ILL; w_dec_illegal = 1'b1; end
    endcase
  end

  // Reset must block acceptance in the same cycle, not only from the next one
  assign w_accept = (r_state == S_IDLE) && InValid && !Reset;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (InValid) begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
          if (w_dec_illegal) begin
            w_next_state = S_TRAP;
          end else begin
            w_next_state = S_EXEC;
          end
`else
          w_next_state = S_EXEC;
`endif
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_EXEC: w_next_state = S_DONE;
      S_DONE: begin
        if (OutReady) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DONE;
        end
      end
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:  w_next_state = S_TRAP;
`else
      S_TRAP:  w_next_state = S_IDLE;
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  // Issue registers (load on accept) and response capture (end of EXEC)
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_alu_op      <= 3'b000;
      r_alu_a       <= 32'h0000_0000;
      r_alu_b       <= 32'h0000_0000;
      r_illegal     <= 1'b0;
      r_is_beq      <= 1'b0;
      r_is_bne      <= 1'b0;
      r_out_result  <= 32'h0000_0000;
      r_out_zero    <= 1'b0;
      r_out_carry   <= 1'b0;
      r_out_branch  <= 1'b0;
      r_out_illegal <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_op  <= w_dec_op;
        r_alu_a   <= RegA;
        r_alu_b   <= RegB;
        r_illegal <= w_dec_illegal;
        r_is_beq  <= w_dec_beq;
        r_is_bne  <= w_dec_bne;
      end
      if (r_state == S_EXEC) begin
        if (r_illegal) begin
          // Illegal requests return a fixed response and ignore the ALU.
          r_out_result  <= 32'h0000_0000;
          r_out_zero    <= 1'b1;
          r_out_carry   <= 1'b0;
          r_out_branch  <= 1'b0;
          r_out_illegal <= 1'b1;
        end else begin
          r_out_result  <= AluResult;
          r_out_zero    <= AluZero;
          // Carry only has meaning for the arithmetic ops.
          r_out_carry   <= ((r_alu_op == ALU_ADD) || (r_alu_op == ALU_SUB)) ? AluCarryOut : 1'b0;
          r_out_branch  <= r_is_beq ? AluZero : (r_is_bne ? ~AluZero : 1'b0);
          r_out_illegal <= 1'b0;
        end
      end
    end
  end

  assign InReady        = (r_state == S_IDLE) && !Reset;
  assign OutValid       = (r_state == S_DONE);
  assign AluOp          = r_alu_op;
  assign AluA           = r_alu_a;
  assign AluB           = r_alu_b;
  assign OutResult      = r_out_result;
  assign OutZero        = r_out_zero;
  assign OutCarry       = r_out_carry;
  assign OutBranchTaken = r_out_branch;
  assign OutIllegal     = r_out_illegal;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  assign Trap           = (r_state == S_TRAP);
`else
  assign Trap           = 1'b0;
`endif

endmodule
